// File: rtl/airi5c_hasti_initiator_if.sv
// Command/response stream plus AHB-Lite (HASTI) bus signals for the initiator.
// The master modport is the initiator side; the slave modport is the environment/responder side.
interface airi5c_hasti_initiator_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] cmd_addr;
   logic        cmd_write;
   logic [2:0]  cmd_size;
   logic [31:0] cmd_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_error;
   logic [31:0] haddr;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [2:0]  hburst;
   logic        hmastlock;
   logic [3:0]  hprot;
   logic [1:0]  htrans;
   logic [31:0] hwdata;
   logic [31:0] hrdata;
   logic        hready;
   logic        hresp;

   modport master (
      input  cmd_valid, cmd_addr, cmd_write, cmd_size, cmd_wdata, hrdata, hready, hresp,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_error,
             haddr, hwrite, hsize, hburst, hmastlock, hprot, htrans, hwdata
   );

   modport slave (
      output cmd_valid, cmd_addr, cmd_write, cmd_size, cmd_wdata, hrdata, hready, hresp,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_error,
             haddr, hwrite, hsize, hburst, hmastlock, hprot, htrans, hwdata
   );
endinterface

// File: rtl/airi5c_hasti_initiator.sv
// Pipelined HASTI master: one SINGLE/NONSEQ transfer per accepted command, response 3 cycles after accept.
// Commands stall while the address phase is blocked by hready or an ERROR is unwinding; responses have no backpressure.
module airi5c_hasti_initiator #(
   parameter logic [3:0] HPROT_VAL  = 4'b0011,
   parameter logic [2:0] HBURST_VAL = 3'b000
) (
   input  logic                            clk_i,
   input  logic                            nreset_i,
   airi5c_hasti_initiator_if.master        bus_io
);
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   typedef enum logic {ST_RUN = 1'b0, ST_ABORT = 1'b1} state_e;

   state_e      state_q, state_d;
   logic        aborting;
   logic        released_q;

   logic        aph_vld_q, aph_write_q;
   logic [31:0] aph_addr_q, aph_wdata_q;
   logic [2:0]  aph_size_q;

   logic        dph_vld_q, dph_write_q;
   logic [2:0]  dph_size_q;
   logic [1:0]  dph_lane_q;
   logic [31:0] dph_wdata_q;

   logic        rsp_vld_q, rsp_err_q;
   logic [31:0] rsp_rdata_q;

   logic        cmd_fire, advance, complete;
   logic [2:0]  cmd_size_eff;
   logic [31:0] rd_shift, rdata_lane, wdata_repl;

   // ERROR is two cycles: first cycle (hready=0) arms the abort, second (hready=1) ends it.
   always_comb begin
      state_d  = state_q;
      aborting = 1'b0;
      case (state_q)
         ST_RUN:   if (dph_vld_q && bus_io.hresp && !bus_io.hready) state_d = ST_ABORT;
         ST_ABORT: begin
            aborting = 1'b1;
            if (bus_io.hready) state_d = ST_RUN;
         end
         default:  state_d = ST_RUN;
      endcase
   end

   assign bus_io.cmd_ready = released_q && (!aph_vld_q || bus_io.hready) && !aborting;
   assign cmd_fire         = bus_io.cmd_valid && bus_io.cmd_ready;
   assign advance          = bus_io.hready && !aborting;
   assign complete         = dph_vld_q && bus_io.hready;
   assign cmd_size_eff     = (bus_io.cmd_size > 3'd2) ? 3'd2 : bus_io.cmd_size;

   always_comb begin
      rd_shift   = bus_io.hrdata >> {dph_lane_q, 3'b000};
      rdata_lane = rd_shift;
      wdata_repl = dph_wdata_q;
      case (dph_size_q)
         3'd0: begin
            rdata_lane = {24'd0, rd_shift[7:0]};
            wdata_repl = {4{dph_wdata_q[7:0]}};
         end
         3'd1: begin
            rdata_lane = {16'd0, rd_shift[15:0]};
            wdata_repl = {2{dph_wdata_q[15:0]}};
         end
         default: ;
      endcase
      if (dph_write_q) rdata_lane = 32'd0;
   end

   assign bus_io.htrans    = (aph_vld_q && !aborting) ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign bus_io.haddr     = aph_addr_q;
   assign bus_io.hwrite    = aph_write_q;
   assign bus_io.hsize     = aph_size_q;
   assign bus_io.hburst    = HBURST_VAL;
   assign bus_io.hmastlock = 1'b0;
   assign bus_io.hprot     = HPROT_VAL;
   assign bus_io.hwdata    = wdata_repl;
   assign bus_io.rsp_valid = rsp_vld_q;
   assign bus_io.rsp_rdata = rsp_rdata_q;
   assign bus_io.rsp_error = rsp_err_q;

   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         state_q     <= ST_RUN;
         released_q  <= 1'b0;
         aph_vld_q   <= 1'b0;
         aph_write_q <= 1'b0;
         aph_addr_q  <= 32'd0;
         aph_wdata_q <= 32'd0;
         aph_size_q  <= 3'd0;
         dph_vld_q   <= 1'b0;
         dph_write_q <= 1'b0;
         dph_size_q  <= 3'd0;
         dph_lane_q  <= 2'd0;
         dph_wdata_q <= 32'd0;
         rsp_vld_q   <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= 32'd0;
      end else begin
         state_q    <= state_d;
         released_q <= 1'b1;

         // Abort completion retires DPH but keeps APH so it is re-issued next cycle.
         if (advance) begin
            dph_vld_q <= aph_vld_q;
            if (aph_vld_q) begin
               dph_write_q <= aph_write_q;
               dph_size_q  <= aph_size_q;
               dph_lane_q  <= aph_addr_q[1:0];
               dph_wdata_q <= aph_wdata_q;
            end
         end else if (aborting && bus_io.hready) begin
            dph_vld_q <= 1'b0;
         end

         if (cmd_fire) begin
            aph_vld_q   <= 1'b1;
            aph_addr_q  <= bus_io.cmd_addr;
            aph_write_q <= bus_io.cmd_write;
            aph_size_q  <= cmd_size_eff;
            aph_wdata_q <= bus_io.cmd_wdata;
         end else if (advance) begin
            aph_vld_q <= 1'b0;
         end

         rsp_vld_q <= complete;
         if (complete) begin
            rsp_err_q   <= bus_io.hresp;
            rsp_rdata_q <= rdata_lane;
         end
      end
   end
endmodule

// File: tb/tb_airi5c_hasti_initiator.sv
// Randomized bench: memory responder with wait states and ERROR region, plus a
// transaction-level scoreboard of expected responses and bus transfers.
`timescale 1ns/1ps
module tb_airi5c_hasti_initiator;
   logic clk = 1'b0;
   logic nreset = 1'b1;
   always #5 clk = ~clk;

   airi5c_hasti_initiator_if bus ();

   airi5c_hasti_initiator dut (
      .clk_i    (clk),
      .nreset_i (nreset),
      .bus_io   (bus)
   );

   typedef struct {
      logic [31:0] addr;
      logic        write;
      logic [2:0]  size;
      logic [31:0] wdata;
   } cmd_t;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
   } rsp_t;

   cmd_t        src_q[$];
   cmd_t        bus_q[$];
   rsp_t        exp_q[$];
   logic [31:0] mem     [64];
   logic [31:0] ref_mem [64];

   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc = 0;
   int          first_fire_cyc = -1;
   int          first_rsp_cyc  = -1;
   int          streak = 0;
   int          max_streak = 0;
   int          min_waits = 0;
   logic        force_ready = 1'b0;

   cmd_t        cur;
   logic        have_cmd = 1'b0;
   cmd_t        dp_c;
   logic        dp_vld = 1'b0;
   logic        dp_err = 1'b0;
   int          dp_stage = 0;
   int          dp_waits = 0;
   logic        rsp_due = 1'b0;
   logic        prev_hold = 1'b0;
   logic [31:0] prev_haddr = 32'd0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [2:0] eff_size(input logic [2:0] s);
      return (s > 3'd2) ? 3'd2 : s;
   endfunction

   function automatic logic [31:0] size_mask(input logic [2:0] s);
      case (eff_size(s))
         3'd0:    return 32'h0000_00FF;
         3'd1:    return 32'h0000_FFFF;
         default: return 32'hFFFF_FFFF;
      endcase
   endfunction

   function automatic logic [31:0] lane_mask(input logic [31:0] a, input logic [2:0] s);
      return size_mask(s) << (8 * a[1:0]);
   endfunction

   function automatic logic [31:0] repl(input logic [31:0] d, input logic [2:0] s);
      logic [31:0] m;
      m = size_mask(s);
      if (m == 32'hFF)   return (d & m) * 32'h0101_0101;
      if (m == 32'hFFFF) return (d & m) * 32'h0001_0001;
      return d;
   endfunction

   function automatic logic is_err(input logic [31:0] a);
      return a[8];
   endfunction

   // Reference: responses come back in command order; ERROR writes leave memory untouched.
   task automatic model_accept(input cmd_t c);
      rsp_t        r;
      logic [31:0] m;
      int          sh;
      m  = size_mask(c.size);
      sh = 8 * c.addr[1:0];
      r.err   = is_err(c.addr);
      r.rdata = 32'd0;
      if (c.write) begin
         if (!r.err)
            ref_mem[c.addr[7:2]] = (ref_mem[c.addr[7:2]] & ~(m << sh)) | ((c.wdata & m) << sh);
      end else begin
         r.rdata = (ref_mem[c.addr[7:2]] >> sh) & m;
      end
      bus_q.push_back(c);
      exp_q.push_back(r);
   endtask

   task automatic cycle_step();
      logic fire, take, done;
      rsp_t e;
      logic [31:0] lm;
      @(negedge clk);
      cyc++;

      check_val("rsp_valid", bus.rsp_valid, rsp_due);
      if (bus.rsp_valid) begin
         if (exp_q.size() == 0) check_val("rsp_unexpected", 1, 0);
         else begin
            e = exp_q.pop_front();
            check_val("rsp_error", bus.rsp_error, e.err);
            if (!e.err) check_val("rsp_rdata", bus.rsp_rdata, e.rdata);
            if (first_rsp_cyc < 0) first_rsp_cyc = cyc;
         end
      end
      if (prev_hold) begin
         check_val("haddr_hold", bus.haddr, prev_haddr);
         check_val("htrans_hold", bus.htrans, 2'b10);
      end
      if (dp_vld && dp_err && dp_stage == 1) check_val("htrans_err2", bus.htrans, 2'b00);

      if (dp_vld) begin
         if (dp_err) begin
            bus.hready = (dp_stage == 1);
            bus.hresp  = 1'b1;
            bus.hrdata = $urandom;
         end else if (dp_waits > 0) begin
            bus.hready = 1'b0;
            bus.hresp  = 1'b0;
            bus.hrdata = $urandom;
         end else begin
            bus.hready = 1'b1;
            bus.hresp  = 1'b0;
            bus.hrdata = dp_c.write ? $urandom : mem[dp_c.addr[7:2]];
         end
      end else begin
         bus.hready = force_ready ? 1'b1 : ($urandom_range(0, 3) != 0);
         bus.hresp  = 1'b0;
         bus.hrdata = $urandom;
      end

      if (!have_cmd && src_q.size() > 0 && (force_ready || $urandom_range(0, 3) != 0)) begin
         cur = src_q.pop_front();
         have_cmd = 1'b1;
      end
      bus.cmd_valid = have_cmd;
      bus.cmd_addr  = cur.addr;
      bus.cmd_write = cur.write;
      bus.cmd_size  = cur.size;
      bus.cmd_wdata = cur.wdata;
      #1;

      fire = bus.cmd_valid && bus.cmd_ready;
      take = (bus.htrans == 2'b10) && bus.hready;
      done = dp_vld && bus.hready;
      prev_hold  = (bus.htrans == 2'b10) && !bus.hready && !bus.hresp;
      prev_haddr = bus.haddr;
      rsp_due    = done;
      streak     = take ? streak + 1 : 0;
      if (streak > max_streak) max_streak = streak;

      if (done) begin
         if (dp_c.write && !dp_err) begin
            check_val("hwdata", bus.hwdata, repl(dp_c.wdata, dp_c.size));
            lm = lane_mask(dp_c.addr, dp_c.size);
            mem[dp_c.addr[7:2]] = (mem[dp_c.addr[7:2]] & ~lm) | (bus.hwdata & lm);
         end
         dp_vld = 1'b0;
      end else if (dp_vld) begin
         if (dp_err) dp_stage = 1;
         else dp_waits--;
      end

      if (take) begin
         if (bus_q.size() == 0) check_val("take_unexpected", 1, 0);
         else begin
            dp_c = bus_q.pop_front();
            check_val("haddr", bus.haddr, dp_c.addr);
            check_val("hwrite", bus.hwrite, dp_c.write);
            check_val("hsize", bus.hsize, eff_size(dp_c.size));
            dp_vld   = 1'b1;
            dp_err   = is_err(dp_c.addr);
            dp_stage = 0;
            dp_waits = force_ready ? 0 : $urandom_range(min_waits, 3);
         end
      end

      if (fire) begin
         model_accept(cur);
         have_cmd = 1'b0;
         if (first_fire_cyc < 0) first_fire_cyc = cyc;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((src_q.size() > 0 || have_cmd || bus_q.size() > 0 || exp_q.size() > 0 ||
              dp_vld || rsp_due) && n < 3000) begin
         cycle_step();
         n++;
      end
      check_val("drain_timeout", (n >= 3000), 0);
   endtask

   function automatic cmd_t mk(input logic [31:0] a, input logic w, input logic [2:0] s, input logic [31:0] d);
      cmd_t c;
      c.addr = a; c.write = w; c.size = s; c.wdata = d;
      return c;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no completion, expected finish within time limit");
      $fatal(1, "timeout");
   end

   initial begin
      cmd_t        c;
      logic [31:0] a;
      logic [2:0]  s;
      int          n;

      for (int i = 0; i < 64; i++) begin
         mem[i]     = $urandom;
         ref_mem[i] = mem[i];
      end
      bus.cmd_valid = 1'b0;
      bus.cmd_addr  = 32'd0;
      bus.cmd_write = 1'b0;
      bus.cmd_size  = 3'd0;
      bus.cmd_wdata = 32'd0;
      bus.hrdata    = 32'd0;
      bus.hready    = 1'b1;
      bus.hresp     = 1'b0;
      cur = mk(32'd0, 1'b0, 3'd0, 32'd0);

      #2 nreset = 1'b0;
      repeat (3) @(negedge clk);
      check_val("rst_htrans", bus.htrans, 2'b00);
      check_val("rst_haddr", bus.haddr, 32'd0);
      check_val("rst_hwrite", bus.hwrite, 1'b0);
      check_val("rst_hsize", bus.hsize, 3'd0);
      check_val("rst_hwdata", bus.hwdata, 32'd0);
      check_val("rst_cmd_ready", bus.cmd_ready, 1'b0);
      check_val("rst_rsp_valid", bus.rsp_valid, 1'b0);
      check_val("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
      check_val("rst_rsp_error", bus.rsp_error, 1'b0);
      check_val("hburst", bus.hburst, 3'b000);
      check_val("hprot", bus.hprot, 4'b0011);
      check_val("hmastlock", bus.hmastlock, 1'b0);

      nreset = 1'b1;
      #1 check_val("cmd_ready_at_release", bus.cmd_ready, 1'b0);
      @(negedge clk);
      check_val("cmd_ready_after_release", bus.cmd_ready, 1'b1);
      check_val("idle_htrans", bus.htrans, 2'b00);
      repeat (5) cycle_step();

      // Back-to-back word writes at zero wait states.
      force_ready    = 1'b1;
      first_fire_cyc = -1;
      first_rsp_cyc  = -1;
      max_streak     = 0;
      for (int i = 0; i < 4; i++)
         src_q.push_back(mk(32'h8000_0000 + 4 * i, 1'b1, 3'd2, 32'h1111_0000 + i));
      drain();
      check_val("latency", first_rsp_cyc - first_fire_cyc, 3);
      check_val("nonseq_streak_ge4", (max_streak >= 4), 1);

      // Byte write then byte read of the same lane.
      src_q.push_back(mk(32'h8000_0003, 1'b1, 3'd0, 32'h1234_56A5));
      src_q.push_back(mk(32'h8000_0003, 1'b0, 3'd0, 32'd0));
      drain();
      check_val("byte_mem", mem[0] & 32'hFF00_0000, 32'hA500_0000);

      // Wait states, then an ERROR read with a write queued behind it.
      force_ready = 1'b0;
      min_waits   = 3;
      src_q.push_back(mk(32'h8000_0020, 1'b0, 3'd2, 32'd0));
      src_q.push_back(mk(32'h8000_0024, 1'b0, 3'd1, 32'd0));
      drain();
      min_waits = 0;
      src_q.push_back(mk(32'h8000_0104, 1'b0, 3'd2, 32'd0));
      src_q.push_back(mk(32'h8000_0010, 1'b1, 3'd2, 32'hCAFE_F00D));
      src_q.push_back(mk(32'h8000_0010, 1'b0, 3'd2, 32'd0));
      drain();

      // Random mix of sizes, directions, waits and errors.
      for (int i = 0; i < 300; i++) begin
         s = 3'($urandom_range(0, 3));
         a = 32'h8000_0000 | 32'($urandom_range(0, 255));
         if ($urandom_range(0, 7) == 0) a[8] = 1'b1;
         if (eff_size(s) == 3'd1) a[0] = 1'b0;
         if (eff_size(s) == 3'd2) a[1:0] = 2'b00;
         src_q.push_back(mk(a, 1'($urandom_range(0, 1)), s, $urandom));
      end
      drain();

      // Reset in the data phase of a read abandons it silently.
      min_waits = 2;
      src_q.push_back(mk(32'h8000_0030, 1'b0, 3'd2, 32'd0));
      n = 0;
      while (!dp_vld && n < 50) begin
         cycle_step();
         n++;
      end
      check_val("reach_dphase", dp_vld, 1'b1);
      @(posedge clk);
      #2 nreset = 1'b0;
      #1;
      check_val("arst_htrans", bus.htrans, 2'b00);
      check_val("arst_haddr", bus.haddr, 32'd0);
      check_val("arst_cmd_ready", bus.cmd_ready, 1'b0);
      check_val("arst_rsp_valid", bus.rsp_valid, 1'b0);
      check_val("arst_hwdata", bus.hwdata, 32'd0);
      bus_q.delete();
      exp_q.delete();
      src_q.delete();
      dp_vld = 1'b0;
      rsp_due = 1'b0;
      prev_hold = 1'b0;
      have_cmd = 1'b0;
      bus.cmd_valid = 1'b0;
      @(negedge clk);
      nreset = 1'b1;
      min_waits = 0;
      repeat (6) cycle_step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/airi5c_hasti_initiator.md
Name: airi5c_hasti_initiator

Overview:
- AHB-Lite (HASTI) bus master that converts a simple valid/ready command stream into single HASTI transfers (SINGLE, NONSEQ).
- Drives any HASTI responder: the FPGA block-RAM port, the core's memory ports, or a mem_arbiter input.
- Used by test/boot infrastructure (memory preload, DMA-style copies) as the initiator side of the memory interface.
- Pipelined: the address phase of transfer N+1 overlaps the data phase of N, giving one transfer per cycle at zero wait states.

Parameters:
- HPROT_VAL, 4'b0011, constant value driven on hprot (data access, privileged).
- HBURST_VAL, 3'b000, constant value driven on hburst (SINGLE).

Ports:
- clk  in  1  clock
- nreset  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a rising clk edge
- cmd_addr  in  32  byte address (naturally aligned for cmd_size)
- cmd_write  in  1  1 = write, 0 = read
- cmd_size  in  3  0 = byte, 1 = half, 2 = word; values above 2 are treated as 2
- cmd_wdata  in  32  write data, right-aligned (LSBs)
- rsp_valid  out  1  one-cycle pulse per completed transfer
- rsp_rdata  out  32  read data, lane-extracted, zero-extended; 0 for writes
- rsp_error  out  1  responder returned ERROR
- haddr  out  32  HASTI address
- hwrite  out  1  HASTI write
- hsize  out  3  HASTI size
- hburst  out  3  = HBURST_VAL
- hmastlock  out  1  constant 0
- hprot  out  4  = HPROT_VAL
- htrans  out  2  IDLE = 2'b00, NONSEQ = 2'b10
- hwdata  out  32  write data in data phase
- hrdata  in  32  read data
- hready  in  1  transfer done / bus ready
- hresp  in  1  0 = OKAY, 1 = ERROR

Behaviour:
Clock and reset:
- One clock, clk.
- Reset nreset is asynchronous, active-low.
- While nreset=0: htrans=IDLE, haddr=0, hwrite=0, hsize=0, hwdata=0, cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_error=0, and the pipeline registers are cleared.
- Reset asserted mid-transfer abandons both phases without issuing a response.

Pipeline state (all bus outputs registered):
- Address-phase register APH (valid, addr, write, size, wdata).
- Data-phase register DPH (valid, write, size, addr[1:0], wdata).
- ABORT flag.

Command acceptance:
- cmd_ready = nreset_released && (!APH.valid || hready) && !ABORT.
- A command fire loads APH. Bus signals for it appear the cycle after acceptance.

Bus outputs:
- htrans = NONSEQ when APH.valid && !ABORT, else IDLE.
- haddr, hwrite and hsize reflect APH and hold their last value while idle.

Phase advance:
- On an edge with hready=1 and !ABORT: DPH <= APH (valid iff APH.valid); APH <= accepted command, else invalid.
- On an edge with hready=0: APH and DPH hold, and the address is held stable, as AHB-Lite requires.

Write data:
- hwdata is driven from DPH during the data phase.
- Byte writes: byte replicated on all four lanes.
- Halfword writes: halfword replicated on both halves.
- Word writes: as-is.

Response:
- On an edge where DPH.valid && hready=1, the next cycle carries rsp_valid=1 and rsp_error=hresp.
- rsp_rdata = lane selected by DPH.addr[1:0] and DPH.size, zero-extended (0 for writes).
- rsp_valid is otherwise 0. There is no backpressure; the consumer must accept every pulse.

Latency and throughput:
- Accept at edge E0, address phase in cycle 1, data phase in cycle 2 (zero waits), rsp_valid in cycle 3.
- Each responder wait state adds one cycle.
- Sustained throughput is 1 transfer/cycle.

Error (two-cycle AHB ERROR):
- Edge sampling DPH.valid && hresp=1 && hready=0 sets ABORT.
- While ABORT=1: htrans=IDLE (pending APH is cancelled on the bus but retained), cmd_ready=0.
- Edge with hready=1 while ABORT: DPH completes (rsp_error=1), APH is retained, ABORT clears.
- The retained APH is re-driven NONSEQ the following cycle.
- An error on a transfer does not affect later transfers.

Boundaries:
- cmd_valid while APH is full and hready=0: not accepted, and cmd fields are not sampled.
- hready=0 with no transfer in the data phase is legal; the master simply holds.
- Misaligned commands: behaviour undefined; the caller guarantees alignment.

Test Plan:
- Reset, then idle with cmd_valid=0 -> htrans=IDLE, cmd_ready=1 one cycle after reset release, rsp_valid never asserted.
- Four back-to-back word writes to 0x80000000..0x8000000C, hready=1 -> htrans=NONSEQ for 4 consecutive cycles, hwdata trails haddr by one cycle, 4 rsp_valid pulses with rsp_error=0.
- Byte write 0xA5 to 0x80000003 followed by byte read from 0x80000003, with a responder model -> hsize=0, hwdata=0xA5A5A5A5, read returns rsp_rdata=0x000000A5.
- Word read with hready held low for 3 cycles and a second command queued -> haddr/htrans of the second transfer stable through the wait cycles, first rsp_valid 3 cycles late, second follows next cycle.
- Responder returns ERROR (hresp=1 with hready 0 then 1) on a read while a write to 0x80000010 is pending -> htrans=IDLE in the second error cycle, rsp_error=1 for the read, write re-issued NONSEQ afterwards and completes with rsp_error=0.
- nreset pulsed low during the data phase of a read -> all outputs return to reset values asynchronously, and no rsp_valid is issued for the abandoned transfer.
